ld_st_unit: RTL
===============

# ld_st_unit

Load/store unit sitting between the 8-entry register file and data memory. It takes an address from read port A, store data from read port B (r2 when a store is active), and performs a byte access to a local 256×8 data memory. A small FSM models memory latency and stalls the core while busy. On loads it returns the byte with a one-cycle `mem_to_reg` strobe that writes r2 in the register file.

## Interface
- `AW`, 8, address width; memory depth is 2**AW bytes
- `LAT`, 1, memory access latency in clock edges; legal range 1..4, elaboration error otherwise
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  access request from decode
- `req_we`  in  1  1 = store, 0 = load; qualified by `req_valid`
- `addr`  in  AW  byte address (register file port A)
- `wdata`  in  8  store data (register file port B = r2)
- `req_ready`  out  1  unit can accept a request this cycle
- `stall`  out  1  core must hold PC/decode; equals `~req_ready`
- `resp_valid`  out  1  one-cycle completion pulse, loads and stores
- `mem_to_reg`  out  1  one-cycle pulse, loads only; drives register file `MemtoReg`
- `rdata`  out  8  load result; drives register file `dat_in` while `mem_to_reg` is high

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `req_ready`=1. On an edge with `req_valid`=1:
  - latch `addr`, `req_we` and `wdata`
  - load `cnt`=LAT-1 and go to BUSY
  - a store writes `mem[addr]`=`wdata` on that same edge
- BUSY: `req_ready`=0. Each edge with `cnt`≠0 decrements `cnt`. The edge with `cnt`==0 moves to DONE. On that edge a load captures `rdata`=mem[addr_q].
- DONE: lasts exactly one cycle.
  - `resp_valid`=1
  - `mem_to_reg`=1 only if the latched op is a load
  - `req_ready`=0
  - next edge returns to IDLE
- Requests while not in IDLE are ignored. Decode holds `req_valid` under `stall`.
- `rdata` holds the last load result until the next load completes. Stores never change `rdata`.
- Addresses use the full AW bits with no wrap logic. Address 255 is a valid ordinary location.
- Memory contents are not reset. Simulation initialises every byte to 0.
- Reset asserted mid-operation:
  - FSM goes to IDLE and `cnt` clears
  - `resp_valid`, `mem_to_reg` and `rdata` go to 0
  - a pending load never strobes `mem_to_reg`
  - a store already written on its accept edge stays written

## Timing
- Reset values:
  - state=IDLE
  - `req_ready`=1, `stall`=0
  - `resp_valid`=0, `mem_to_reg`=0, `rdata`=0x00
- Accept edge E0. Then `resp_valid` and `mem_to_reg` are high in the cycle between edges E(LAT) and E(LAT+1).
- Throughput: one access per LAT+2 cycles. `req_ready` rises in the cycle after DONE.
- Store→load to the same address, back to back: the load returns the stored byte, because the write occurs at the store's accept edge.
- `mem_to_reg` and `rdata` are both registered, so the register file samples a stable `dat_in` at edge E(LAT+1).
- All outputs are glitch-free register outputs, except `stall`, which is the inverse of the registered `req_ready`.

## Structure
- Shared package `jay_pkg`:
  - `lsu_state_t` enum {IDLE, BUSY, DONE}
  - constants `DATA_W`=8 and `REG_MEM`=3'd2 (r2, the load/store data register)
- Sub-module `data_mem`:
  - 2**AW×8 array, synchronous write, synchronous read on a read-enable strobe
  - ports `clk`, `we`, `waddr`, `wdata`, `re`, `raddr`, `rdata`
  - `ld_st_unit` holds the FSM, latency counter and request latch

## Test plan
- Reset mid-load:
  - LAT=3, load accepted, `rst_n` low in BUSY → no `mem_to_reg` pulse, outputs return to reset values
  - after reset, a load of that address returns the preserved memory byte
- Store then load, LAT=1:
  - store addr=0x10 wdata=0xA5 → `resp_valid` pulse, `mem_to_reg`=0
  - load addr=0x10 → `mem_to_reg` pulse, `rdata`=0xA5, 3 cycles apart
- Latency sweep: LAT=1..4, load addr=0x00 → `resp_valid` exactly LAT edges after accept; `stall` high for LAT+1 cycles.
- Busy-ignore: second request with addr=0x20, we=1 held during BUSY → not accepted until `req_ready`; mem[0x20] unchanged until then.
- Boundary address: store 0xFF to addr 0xFF, load 0xFF → `rdata`=0xFF; mem[0x00] unaffected.
- `rdata` hold: load 0x3C, then store 0x77 elsewhere → `rdata` stays 0x3C; `mem_to_reg` stays 0 for the store.

Source files
------------

// File: rtl/jay_pkg.sv
// rtl/jay_pkg.sv - shared types and constants for the load/store unit
package jay_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_t;

    localparam int         DATA_W  = 8;
    // Register file index written by loads and read as store data.
    localparam logic [2:0] REG_MEM = 3'd2;

endpackage

// File: rtl/ld_st_unit_if.sv
// rtl/ld_st_unit_if.sv - decode-to-LSU request/response bundle
interface ld_st_unit_if
    import jay_pkg::*;
#(
    parameter int AW = 8
);
    logic              req_valid;
    logic              req_we;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic              req_ready;
    logic              stall;
    logic              resp_valid;
    logic              mem_to_reg;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, req_we, addr, wdata,
        input  req_ready, stall, resp_valid, mem_to_reg, rdata
    );

    modport slave (
        input  req_valid, req_we, addr, wdata,
        output req_ready, stall, resp_valid, mem_to_reg, rdata
    );

endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-wide data memory, synchronous write and strobed synchronous read
module data_mem #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    // Contents are intentionally not reset.
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/ld_st_unit.sv
// rtl/ld_st_unit.sv - load/store unit: request latch, latency FSM and local data memory
module ld_st_unit
    import jay_pkg::*;
#(
    parameter int AW  = 8,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ld_st_unit_if.slave   bus
);
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("ld_st_unit: LAT must be in 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    lsu_state_t        state_q;
    logic [1:0]        cnt_q;
    logic              we_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              mem_to_reg_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem_rdata;
    logic              accept;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // The read is issued on the accept edge; nothing can write the memory
    // again until this access completes, so the held word is still current.
    data_mem #(
        .AW (AW),
        .DW (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (accept && bus.req_we),
        .waddr (bus.addr),
        .wdata (bus.wdata),
        .re    (accept && !bus.req_we),
        .raddr (bus.addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_to_reg_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        cnt_q       <= CNT_INIT;
                        req_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        mem_to_reg_q <= !we_q;
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.stall      = ~req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.rdata      = rdata_q;

endmodule
